// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus the IR/decode handshake.
`timescale 1ns/1ps
interface instr_fetch_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        ir_valid;
   logic [3:0]  opcode;
   logic [11:0] imm12;
   logic [15:0] ir_pc;
   logic        ir_accept;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        halted;

   modport master (
      output imem_req, imem_addr, ir_valid, opcode, imm12, ir_pc, halted,
      input  imem_ack, imem_rdata, ir_accept, redirect, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, ir_valid, opcode, imm12, ir_pc, halted,
      output imem_ack, imem_rdata, ir_accept, redirect, redirect_pc
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: PC-driven word reads latched into the IR; ack->ir_valid and accept/redirect->request one cycle later.
// Decode back-pressure holds IR and stops requests until ir_accept; redirect overrides everything; HALT_OP parks until redirect.
`timescale 1ns/1ps
module instr_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [3:0]  HALT_OP  = 4'hF
) (
   input  logic          clk,
   input  logic          rst_n,
   instr_fetch_if.master bus
);

   typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_HOLD, ST_HALT} state_t;

   state_t      r_state;
   logic [15:0] r_pc;
   logic [15:0] r_ir;
   logic [15:0] r_ir_pc;
   logic        r_req;
   logic        r_vld;
   logic        r_halted;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_BOOT;
         r_pc     <= RESET_PC;
         r_ir     <= 16'h0000;
         r_ir_pc  <= 16'h0000;
         r_req    <= 1'b0;
         r_vld    <= 1'b0;
         r_halted <= 1'b0;
      end else if (bus.redirect) begin
         // Same-cycle ack data and accept are dropped on redirect.
         r_state  <= ST_FETCH;
         r_pc     <= bus.redirect_pc;
         r_req    <= 1'b1;
         r_vld    <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         case (r_state)
            ST_BOOT: begin
               r_state <= ST_FETCH;
               r_req   <= 1'b1;
            end
            ST_FETCH: begin
               if (bus.imem_ack) begin
                  r_ir    <= bus.imem_rdata;
                  r_ir_pc <= r_pc;
                  r_pc    <= r_pc + 16'd1;
                  r_state <= ST_HOLD;
                  r_req   <= 1'b0;
                  r_vld   <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (bus.ir_accept) begin
                  r_vld <= 1'b0;
                  if (r_ir[15:12] == HALT_OP) begin
                     r_state  <= ST_HALT;
                     r_halted <= 1'b1;
                  end else begin
                     r_state <= ST_FETCH;
                     r_req   <= 1'b1;
                  end
               end
            end
            ST_HALT: begin
               r_state <= ST_HALT;
            end
            default: begin
               r_state <= ST_BOOT;
            end
         endcase
      end
   end

   assign bus.imem_req  = r_req;
   assign bus.imem_addr = r_pc;
   assign bus.ir_valid  = r_vld;
   assign bus.opcode    = r_ir[15:12];
   assign bus.imm12     = r_ir[11:0];
   assign bus.ir_pc     = r_ir_pc;
   assign bus.halted    = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations plus randomized traffic against a transaction model.
`timescale 1ns/1ps
module tb_instr_fetch;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   bit   chk_en;

   instr_fetch_if if0 ();
   instr_fetch_if if1 ();

   instr_fetch #(.RESET_PC(16'h0000), .HALT_OP(4'hF)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
   instr_fetch #(.RESET_PC(16'hFFFF), .HALT_OP(4'hF)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model of dut0: what is being requested, presented or parked.
   logic [15:0] m_pc, m_ir, m_irpc;
   logic        m_req, m_vld, m_halt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc <= 16'h0000; m_ir <= 16'h0000; m_irpc <= 16'h0000;
         m_req <= 1'b0; m_vld <= 1'b0; m_halt <= 1'b0;
      end else if (if0.redirect) begin
         m_pc <= if0.redirect_pc; m_req <= 1'b1; m_vld <= 1'b0; m_halt <= 1'b0;
      end else if (!m_req && !m_vld && !m_halt) begin
         m_req <= 1'b1;
      end else if (m_req && if0.imem_ack) begin
         m_ir <= if0.imem_rdata; m_irpc <= m_pc; m_pc <= m_pc + 16'd1;
         m_req <= 1'b0; m_vld <= 1'b1;
      end else if (m_vld && if0.ir_accept) begin
         m_vld <= 1'b0;
         if (m_ir[15:12] == 4'hF) m_halt <= 1'b1;
         else m_req <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_req",    {15'd0, if0.imem_req}, {15'd0, m_req});
         chk("model_addr",   if0.imem_addr,         m_pc);
         chk("model_valid",  {15'd0, if0.ir_valid}, {15'd0, m_vld});
         chk("model_opcode", {12'd0, if0.opcode},   {12'd0, m_ir[15:12]});
         chk("model_imm12",  {4'd0, if0.imm12},     {4'd0, m_ir[11:0]});
         chk("model_ir_pc",  if0.ir_pc,             m_irpc);
         chk("model_halted", {15'd0, if0.halted},   {15'd0, m_halt});
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"},    {15'd0, if0.imem_req}, 16'h0000);
      chk({tag, "_valid"},  {15'd0, if0.ir_valid}, 16'h0000);
      chk({tag, "_opcode"}, {12'd0, if0.opcode},   16'h0000);
      chk({tag, "_imm12"},  {4'd0, if0.imm12},     16'h0000);
      chk({tag, "_ir_pc"},  if0.ir_pc,             16'h0000);
      chk({tag, "_halted"}, {15'd0, if0.halted},   16'h0000);
      chk({tag, "_addr"},   if0.imem_addr,         16'h0000);
      chk({tag, "_addr1"},  if1.imem_addr,         16'hFFFF);
   endtask

   initial begin
      n_tests = 0; n_fail = 0; chk_en = 1'b0;
      rst_n = 1'b0;
      if0.imem_ack = 1'b0; if0.imem_rdata = 16'h0000; if0.ir_accept = 1'b0;
      if0.redirect = 1'b0; if0.redirect_pc = 16'h0000;
      if1.imem_ack = 1'b0; if1.imem_rdata = 16'h0000; if1.ir_accept = 1'b0;
      if1.redirect = 1'b0; if1.redirect_pc = 16'h0000;

      repeat (3) @(negedge clk);
      chk_reset_vals("rst_init");
      chk_en = 1'b1;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("boot_req", {15'd0, if0.imem_req}, 16'h0000);
      @(negedge clk);
      chk("fetch_req", {15'd0, if0.imem_req}, 16'h0001);
      @(negedge clk);

      // Reset asserted mid-request must drop outputs without waiting for a clock edge.
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("rst_mid");
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("boot2_req",  {15'd0, if0.imem_req}, 16'h0000);
      chk("boot2_req1", {15'd0, if1.imem_req}, 16'h0000);
      if1.imem_ack = 1'b1; if1.imem_rdata = 16'h5123;

      for (int w = 0; w < 3; w++) begin
         @(negedge clk);
         chk("wait_req",  {15'd0, if0.imem_req}, 16'h0001);
         chk("wait_addr", if0.imem_addr, 16'h0000);
         if (w == 0) chk("wrap_addr0", if1.imem_addr, 16'hFFFF);
         if (w == 1) begin
            chk("wrap_valid", {15'd0, if1.ir_valid}, 16'h0001);
            chk("wrap_ir_pc", if1.ir_pc, 16'hFFFF);
            chk("wrap_addr1", if1.imem_addr, 16'h0000);
            chk("wrap_imm12", {4'd0, if1.imm12}, 16'h0123);
            if1.imem_ack = 1'b0;
         end
      end
      if0.imem_ack = 1'b1; if0.imem_rdata = 16'h3ABC;
      @(negedge clk);
      if0.imem_ack = 1'b0;
      chk("basic_valid",  {15'd0, if0.ir_valid}, 16'h0001);
      chk("basic_opcode", {12'd0, if0.opcode}, 16'h0003);
      chk("basic_imm12",  {4'd0, if0.imm12}, 16'h0ABC);
      chk("basic_ir_pc",  if0.ir_pc, 16'h0000);
      chk("basic_req",    {15'd0, if0.imem_req}, 16'h0000);

      for (int b = 0; b < 5; b++) begin
         if0.imem_ack = b[0];
         if0.imem_rdata = 16'h7777;
         @(negedge clk);
         chk("bp_imm12", {4'd0, if0.imm12}, 16'h0ABC);
         chk("bp_req",   {15'd0, if0.imem_req}, 16'h0000);
      end
      if0.imem_ack = 1'b0;
      if0.ir_accept = 1'b1;
      @(negedge clk);
      if0.ir_accept = 1'b0;
      chk("accept_req",  {15'd0, if0.imem_req}, 16'h0001);
      chk("accept_addr", if0.imem_addr, 16'h0001);

      if0.imem_ack = 1'b1; if0.imem_rdata = 16'h1234;
      if0.redirect = 1'b1; if0.redirect_pc = 16'h0100; if0.ir_accept = 1'b1;
      @(negedge clk);
      if0.imem_ack = 1'b0; if0.redirect = 1'b0; if0.ir_accept = 1'b0;
      chk("redir_valid",  {15'd0, if0.ir_valid}, 16'h0000);
      chk("redir_req",    {15'd0, if0.imem_req}, 16'h0001);
      chk("redir_addr",   if0.imem_addr, 16'h0100);
      chk("redir_imm12",  {4'd0, if0.imm12}, 16'h0ABC);

      if0.imem_ack = 1'b1; if0.imem_rdata = 16'hF000;
      @(negedge clk);
      if0.imem_ack = 1'b0;
      chk("halt_opcode", {12'd0, if0.opcode}, 16'h000F);
      chk("halt_ir_pc",  if0.ir_pc, 16'h0100);
      if0.ir_accept = 1'b1;
      @(negedge clk);
      for (int h = 0; h < 10; h++) begin
         if0.imem_ack = 1'($urandom_range(0, 1));
         if0.ir_accept = 1'($urandom_range(0, 1));
         chk("halt_halted", {15'd0, if0.halted}, 16'h0001);
         chk("halt_req",    {15'd0, if0.imem_req}, 16'h0000);
         @(negedge clk);
      end
      if0.redirect = 1'b1; if0.redirect_pc = 16'h0020;
      @(negedge clk);
      if0.redirect = 1'b0; if0.imem_ack = 1'b0; if0.ir_accept = 1'b0;
      chk("unhalt_halted", {15'd0, if0.halted}, 16'h0000);
      chk("unhalt_req",    {15'd0, if0.imem_req}, 16'h0001);
      chk("unhalt_addr",   if0.imem_addr, 16'h0020);

      for (int i = 0; i < 4000; i++) begin
         if0.imem_ack    = ($urandom_range(0, 2) == 0);
         if0.imem_rdata  = 16'($urandom);
         if ($urandom_range(0, 7) == 0) if0.imem_rdata[15:12] = 4'hF;
         if0.ir_accept   = 1'($urandom_range(0, 1));
         if0.redirect    = ($urandom_range(0, 31) == 0);
         if0.redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
         if (i == 2000) begin
            #2 rst_n = 1'b0;
            #1 chk_reset_vals("rst_rand");
            @(posedge clk); #1 rst_n = 1'b1;
         end
         @(negedge clk);
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
